// File: rtl/wb_j1_pkg.sv
// -----------------------------------------------------------------------------
// wb_j1_pkg
// Shared definitions for the J1 system-bus arbiter and its neighbours.
//   - WB_J1_AW / WB_J1_DW : default Wishbone address / data widths
//   - WB_J1_UART_BASE     : UART window base, shared with the CPU address decode
//   - arb_state_t         : arbiter state. The encoding is chosen so that it
//                           doubles as the one-hot grant vector
//                           (bit0 = m0, bit1 = m1).
//   - arb_pick()          : round-robin choice between the two requesters
// -----------------------------------------------------------------------------
package wb_j1_pkg;

    localparam int WB_J1_AW = 16;
    localparam int WB_J1_DW = 16;

    localparam logic [15:0] WB_J1_UART_BASE = 16'hF000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_t;

    // On a tie the master that was NOT served last wins. The same rule also
    // covers re-arbitration after a termination: with last_m1 set to the
    // master that just finished, the other master is preferred, and the
    // finishing master is only re-granted when it is the sole requester.
    function automatic arb_state_t arb_pick(input logic req0,
                                            input logic req1,
                                            input logic last_m1);
        arb_state_t pick;
        if (req0 && req1) begin
            pick = last_m1 ? ARB_GNT0 : ARB_GNT1;
        end else if (req0) begin
            pick = ARB_GNT0;
        end else if (req1) begin
            pick = ARB_GNT1;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_j1_arb_timeout.sv
// -----------------------------------------------------------------------------
// wb_j1_arb_timeout
// Watchdog for the arbiter. It counts the granted cycles in which the slave
// gives neither ack nor err, and raises 'expired' once the count reaches
// TIMEOUT. The counter is exactly wide enough to hold TIMEOUT and it
// saturates there, so it cannot wrap.
// Used only in builds that define WB_ARB_TIMEOUT_EN.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   active    : a master currently holds the grant
//   clear     : the current grant terminates on this edge
//   stall     : no ack/err from the slave this cycle
//   expired   : count has reached TIMEOUT while granted
// -----------------------------------------------------------------------------
module wb_j1_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;
    logic          at_limit;

    assign at_limit = (count == CW'(TIMEOUT));
    assign expired  = active & at_limit;

    // Idle time and every termination restart the count, so each new grant
    // starts from zero. Stalled granted cycles advance it up to the limit.
    always_ff @(posedge clk) begin
        if (rst || !active || clear) begin
            count <= '0;
        end else if (stall && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_j1_arbiter.sv
// -----------------------------------------------------------------------------
// wb_j1_arbiter
// Two-master Wishbone arbiter for the J1 system bus. m0 is the CPU data port
// and m1 is the UART loader/debug port. The shared slave bus is granted for
// one transfer at a time in round-robin order. Slave responses are routed
// only to the master that holds the grant.
// Optional build macro: WB_ARB_TIMEOUT_EN. When it is defined, a stalled
// transfer is ended with an error after TIMEOUT stalled cycles.
// Ports:
//   clk, rst                  : system clock, synchronous active-high reset
//   m0_* / m1_*               : master-side Wishbone (cyc, stb, we, adr, dat
//                               in; dat, ack, err out)
//   s_*                       : slave-side Wishbone, a combinational copy of
//                               the granted master
//   gnt_o                     : one-hot grant (bit0 = m0, bit1 = m1), 00 idle
// -----------------------------------------------------------------------------
module wb_j1_arbiter
    import wb_j1_pkg::*;
#(
    parameter int AW      = WB_J1_AW,
    parameter int DW      = WB_J1_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    gnt_o
);

    arb_state_t state;
    logic       last_m1;
    logic       req0, req1;
    logic       sel0, sel1;
    logic       cur_cyc, cur_stb;
    logic       timeout_hit;
    logic       err_any;
    logic       done;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign sel0 = (state == ARB_GNT0);
    assign sel1 = (state == ARB_GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    wb_j1_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .active  (sel0 | sel1),
        .clear   (done),
        .stall   (~(s_ack_i | s_err_i)),
        .expired (timeout_hit)
    );
`else
    // Without the watchdog a stalled slave holds the grant indefinitely.
    // TIMEOUT only matters to the watchdog build.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    // Forward the granted master to the slave bus. When idle, or in an
    // illegal state, the bus stays quiet.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        cur_cyc = 1'b0;
        cur_stb = 1'b0;
        case (state)
            ARB_GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                cur_cyc = m0_cyc_i;
                cur_stb = m0_stb_i;
            end
            ARB_GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                cur_cyc = m1_cyc_i;
                cur_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // Err (from the slave or from the watchdog) takes priority over ack, so
    // a slave that asserts both still terminates the transfer with an error.
    assign err_any  = s_err_i | timeout_hit;
    assign done     = (cur_stb & (s_ack_i | s_err_i)) | timeout_hit;

    assign m0_err_o = sel0 & m0_stb_i & err_any;
    assign m0_ack_o = sel0 & m0_stb_i & s_ack_i & ~err_any;
    assign m1_err_o = sel1 & m1_stb_i & err_any;
    assign m1_ack_o = sel1 & m1_stb_i & s_ack_i & ~err_any;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // The state encoding is the grant vector itself, so gnt_o comes straight
    // from a register.
    assign gnt_o = state;

    // Arbitration FSM. On a termination it re-arbitrates directly into the
    // next grant, with no idle bubble. A master that abandons its cycle
    // before termination releases the bus without moving the round-robin
    // pointer. An unused encoding falls into the default branch with
    // cur_cyc low and recovers to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    state <= arb_pick(req0, req1, last_m1);
                end
                default: begin
                    if (!cur_cyc) begin
                        state <= ARB_IDLE;
                    end else if (done) begin
                        last_m1 <= sel1;
                        state   <= arb_pick(req0, req1, sel1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_j1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_j1_arbiter
// Self-checking bench for wb_j1_arbiter. A behavioural model tracks which
// master owns the bus and who was served last, and it predicts every output
// on every cycle. Directed scenarios add hand-computed literal expectations.
// Honours WB_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_wb_j1_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    // slave responder controls
    logic slv_ack_en;
    logic slv_err_en;
    int   slv_delay;
    int   slv_wait = 0;

    // master emulation: transfers still to perform
    int m0_left;
    int m1_left;

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    // behavioural model: owner -1 = nobody, 0 = m0, 1 = m1
    int mdl_owner;
    int mdl_last;
    int mdl_to;
    bit mdl_valid = 1'b0;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cyc;
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic        a0;
        logic        e0;
        logic        a1;
        logic        e1;
        logic [15:0] rd0;
    } rec_t;

    rec_t hist[$];

    wb_j1_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    always #5 clk = ~clk;

    // Slave answers after slv_delay stalled cycles of a live strobe.
    assign s_ack_i = slv_ack_en && s_cyc_o && s_stb_o && (slv_wait >= slv_delay);
    assign s_err_i = slv_err_en && s_cyc_o && s_stb_o && (slv_wait >= slv_delay);

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && !(s_ack_i || s_err_i)) slv_wait <= slv_wait + 1;
        else                                             slv_wait <= 0;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Round robin: a lone requester wins; on a tie the one not served last.
    function automatic int mdl_pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit mdl_fire();
`ifdef WB_ARB_TIMEOUT_EN
        return (mdl_owner >= 0) && (mdl_to == TO);
`else
        return 1'b0;
`endif
    endfunction

    // Model advances on each clock edge from the values seen just before it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mdl_owner = -1;
                mdl_last  = 1;
                mdl_to    = 0;
                mdl_valid = 1'b1;
            end else if (mdl_valid) begin
                bit r0, r1, cx, sx, fire, fin;
                r0   = m0_cyc_i && m0_stb_i;
                r1   = m1_cyc_i && m1_stb_i;
                fire = mdl_fire();
                if (mdl_owner < 0) begin
                    mdl_owner = mdl_pick(r0, r1, mdl_last);
                    mdl_to    = 0;
                end else begin
                    cx  = (mdl_owner == 0) ? m0_cyc_i : m1_cyc_i;
                    sx  = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
                    fin = (sx && (s_ack_i || s_err_i)) || fire;
                    if (!cx) begin
                        mdl_owner = -1;
                        mdl_to    = 0;
                    end else if (fin) begin
                        mdl_last  = mdl_owner;
                        mdl_owner = mdl_pick(r0, r1, mdl_last);
                        mdl_to    = 0;
                    end else if (!(s_ack_i || s_err_i) && mdl_to < TO) begin
                        mdl_to = mdl_to + 1;
                    end
                end
            end
        end
    end

    // Compare every output against the model once per cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mdl_valid) begin
                logic [1:0]  eg;
                logic        ec, es, ew, ee0, ea0, ee1, ea1, fire;
                logic [15:0] ead, edt;
                fire = mdl_fire();
                eg   = (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
                ec   = (mdl_owner == 0) ? m0_cyc_i : (mdl_owner == 1) ? m1_cyc_i : 1'b0;
                es   = (mdl_owner == 0) ? m0_stb_i : (mdl_owner == 1) ? m1_stb_i : 1'b0;
                ew   = (mdl_owner == 0) ? m0_we_i  : (mdl_owner == 1) ? m1_we_i  : 1'b0;
                ead  = (mdl_owner == 0) ? m0_adr_i : (mdl_owner == 1) ? m1_adr_i : 16'h0;
                edt  = (mdl_owner == 0) ? m0_dat_i : (mdl_owner == 1) ? m1_dat_i : 16'h0;
                ee0  = (mdl_owner == 0) && m0_stb_i && (s_err_i || fire);
                ea0  = (mdl_owner == 0) && m0_stb_i && s_ack_i && !ee0;
                ee1  = (mdl_owner == 1) && m1_stb_i && (s_err_i || fire);
                ea1  = (mdl_owner == 1) && m1_stb_i && s_ack_i && !ee1;
                checkOutput("gnt_o",    32'(gnt_o),    32'(eg));
                checkOutput("s_cyc_o",  32'(s_cyc_o),  32'(ec));
                checkOutput("s_stb_o",  32'(s_stb_o),  32'(es));
                checkOutput("s_we_o",   32'(s_we_o),   32'(ew));
                checkOutput("s_adr_o",  32'(s_adr_o),  32'(ead));
                checkOutput("s_dat_o",  32'(s_dat_o),  32'(edt));
                checkOutput("m0_ack_o", 32'(m0_ack_o), 32'(ea0));
                checkOutput("m0_err_o", 32'(m0_err_o), 32'(ee0));
                checkOutput("m1_ack_o", 32'(m1_ack_o), 32'(ea1));
                checkOutput("m1_err_o", 32'(m1_err_o), 32'(ee1));
                checkOutput("m0_dat_o", 32'(m0_dat_o), 32'(s_dat_i));
                checkOutput("m1_dat_o", 32'(m1_dat_o), 32'(s_dat_i));
            end
        end
    end

    // Start a master's burst of 'count' single transfers.
    task automatic applyStimulus(input int which, input int count, input logic we,
                                 input logic [15:0] adr, input logic [15:0] dat);
        if (which == 0) begin
            m0_left = count; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_left = count; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    // Run n cycles, recording outputs mid-cycle. Masters hold their request
    // until they see ack/err, then move on or release the bus after the edge.
    task automatic runCycles(input int n);
        rec_t r;
        bit   t0, t1;
        hist.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r.gnt = gnt_o;   r.cyc = s_cyc_o; r.we = s_we_o;
            r.adr = s_adr_o; r.dat = s_dat_o;
            r.a0  = m0_ack_o; r.e0 = m0_err_o; r.a1 = m1_ack_o; r.e1 = m1_err_o;
            r.rd0 = m0_dat_o;
            hist.push_back(r);
            t0 = m0_cyc_i && m0_stb_i && (m0_ack_o || m0_err_o);
            t1 = m1_cyc_i && m1_stb_i && (m1_ack_o || m1_err_o);
            @(posedge clk);
            #1;
            if (t0 && m0_left > 0) begin
                m0_left--;
                if (m0_left == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; end
                else m0_adr_i = m0_adr_i + 16'd1;
            end
            if (t1 && m1_left > 0) begin
                m1_left--;
                if (m1_left == 0) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; end
                else m1_adr_i = m1_adr_i + 16'd1;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        m0_left = 0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m1_left = 0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        runCycles(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0, n1;
        rst = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0;
        m0_left = 0; m1_left = 0;
        slv_ack_en = 1'b1; slv_err_en = 1'b0; slv_delay = 1; s_dat_i = 16'hBEEF;
        @(posedge clk);
        #1;

        // reset state
        runCycles(2);
        checkOutput("rst_gnt", 32'(hist[1].gnt), 32'd0);
        checkOutput("rst_cyc", 32'(hist[1].cyc), 32'd0);
        checkOutput("rst_ack", 32'({hist[1].a0, hist[1].e0, hist[1].a1, hist[1].e1}), 32'd0);
        rst = 1'b0;

        // m0 read at 0010, slave acks BEEF one cycle after strobe
        $display("[TB] m0 single read");
        applyStimulus(0, 1, 1'b0, 16'h0010, 16'h0000);
        runCycles(5);
        checkOutput("t1_gnt_n",  32'(hist[0].gnt), 32'd0);
        checkOutput("t1_gnt_n1", 32'(hist[1].gnt), 32'b01);
        checkOutput("t1_adr",    32'(hist[1].adr), 32'h0010);
        checkOutput("t1_noack",  32'(hist[1].a0),  32'd0);
        checkOutput("t1_ack",    32'(hist[2].a0),  32'd1);
        checkOutput("t1_dat",    32'(hist[2].rd0), 32'hBEEF);
        n1 = 0;
        foreach (hist[i]) if (hist[i].a1) n1++;
        checkOutput("t1_m1_ack", 32'(n1), 32'd0);
        checkOutput("t1_idle",   32'(hist[4].gnt), 32'd0);

        // both masters continuously, zero-wait slave: strict alternation, m0 first
        $display("[TB] alternating grants");
        doReset();
        slv_delay = 0;
        applyStimulus(0, 6, 1'b0, 16'h0100, 16'h0000);
        applyStimulus(1, 6, 1'b0, 16'h0300, 16'h0000);
        runCycles(15);
        checkOutput("t2_gnt_n", 32'(hist[0].gnt), 32'd0);
        for (int i = 1; i <= 12; i++)
            checkOutput("t2_alt", 32'(hist[i].gnt), (i % 2 == 1) ? 32'b01 : 32'b10);
        n0 = 0; n1 = 0;
        foreach (hist[i]) begin if (hist[i].a0) n0++; if (hist[i].a1) n1++; end
        checkOutput("t2_m0_acks", 32'(n0), 32'd6);
        checkOutput("t2_m1_acks", 32'(n1), 32'd6);

        // m1 write 1234 to 0200 with m0 idle
        $display("[TB] m1 single write");
        slv_delay = 1;
        applyStimulus(1, 1, 1'b1, 16'h0200, 16'h1234);
        runCycles(5);
        checkOutput("t3_gnt", 32'(hist[1].gnt), 32'b10);
        checkOutput("t3_we",  32'(hist[1].we),  32'd1);
        checkOutput("t3_adr", 32'(hist[1].adr), 32'h0200);
        checkOutput("t3_dat", 32'(hist[1].dat), 32'h1234);
        checkOutput("t3_ack", 32'(hist[2].a1),  32'd1);
        checkOutput("t3_idle", 32'(hist[4].gnt), 32'd0);

        // slave never answers
        $display("[TB] stalled slave");
        slv_ack_en = 1'b0;
        applyStimulus(0, 1, 1'b0, 16'h0040, 16'h0000);
        applyStimulus(1, 1, 1'b0, 16'h0050, 16'h0000);
`ifdef WB_ARB_TIMEOUT_EN
        runCycles(13);
        checkOutput("t4_gnt0",   32'(hist[1].gnt), 32'b01);
        checkOutput("t4_no_err", 32'(hist[4].e0),  32'd0);
        checkOutput("t4_err0",   32'(hist[5].e0),  32'd1);
        checkOutput("t4_gnt1",   32'(hist[6].gnt), 32'b10);
        checkOutput("t4_err1",   32'(hist[10].e1), 32'd1);
        checkOutput("t4_idle",   32'(hist[12].gnt), 32'd0);
`else
        runCycles(101);
        for (int i = 1; i <= 100; i++) checkOutput("t4_hold", 32'(hist[i].gnt), 32'b01);
        slv_ack_en = 1'b1;
        slv_delay  = 0;
        runCycles(4);
        checkOutput("t4_rel_ack0", 32'(hist[0].a0), 32'd1);
        checkOutput("t4_rel_ack1", 32'(hist[1].a1), 32'd1);
        checkOutput("t4_idle",     32'(hist[3].gnt), 32'd0);
`endif

        // reset while m1 is granted and the slave acks in that same cycle
        $display("[TB] reset mid-transfer");
        slv_ack_en = 1'b1; slv_err_en = 1'b0; slv_delay = 1;
        applyStimulus(1, 1, 1'b0, 16'h0060, 16'h0000);
        runCycles(2);
        checkOutput("t5_gnt1", 32'(hist[1].gnt), 32'b10);
        rst = 1'b1;
        runCycles(1);
        checkOutput("t5_ack_fwd", 32'(hist[0].a1), 32'd1);
        rst = 1'b0;
        runCycles(1);
        checkOutput("t5_idle", 32'(hist[0].gnt), 32'd0);
        checkOutput("t5_cyc",  32'(hist[0].cyc), 32'd0);
        slv_delay = 0;
        applyStimulus(0, 1, 1'b0, 16'h0070, 16'h0000);
        applyStimulus(1, 1, 1'b0, 16'h0080, 16'h0000);
        runCycles(5);
        checkOutput("t5_tie_m0", 32'(hist[1].gnt), 32'b01);
        checkOutput("t5_then_m1", 32'(hist[2].gnt), 32'b10);

        // ack and err together: only err is delivered, arbitration continues
        $display("[TB] ack with err");
        slv_err_en = 1'b1;
        applyStimulus(0, 1, 1'b0, 16'h0090, 16'h0000);
        applyStimulus(1, 1, 1'b0, 16'h00A0, 16'h0000);
        runCycles(5);
        checkOutput("t6_err0", 32'(hist[1].e0), 32'd1);
        checkOutput("t6_ack0", 32'(hist[1].a0), 32'd0);
        checkOutput("t6_gnt1", 32'(hist[2].gnt), 32'b10);
        checkOutput("t6_err1", 32'(hist[2].e1), 32'd1);
        checkOutput("t6_ack1", 32'(hist[2].a1), 32'd0);
        checkOutput("t6_idle", 32'(hist[4].gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
